// File: rtl/fetch_unit.sv
// Instruction fetch: request a word, hold it until downstream consumes it,
// then advance the PC or redirect; misaligned redirects lock into FAULT.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8,
    output logic        fault
);

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        HOLD  = 2'b01,
        FAULT = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        fault_q, fault_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        fault_d = fault_q;
        unique case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!stall) begin
                    if (!PCSrc) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = FETCH;
                    end else if (BranchTarget[1:0] == 2'b00) begin
                        pc_d    = BranchTarget;
                        state_d = FETCH;
                    end else begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    // Request is suppressed in any cycle where reset is asserted
    assign imem_req   = (state_q == FETCH) && !reset;
    assign imem_addr  = pc_q;
    assign InstrValid = (state_q == HOLD);
    assign Instr      = instr_q;
    assign PC         = pc_q;
    assign PCPlus8    = pc_q + 32'd8;
    assign fault      = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random
// traffic compared against a transaction-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        PCSrc;
    logic [31:0] BranchTarget;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus8;
    logic        fault;

    int errors = 0;
    int checks = 0;

    // Reference model: the current PC, the word held for downstream (if any)
    // and whether the unit is dead after a bad redirect.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_have;
    bit          m_dead;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .stall(stall),
        .PCSrc(PCSrc),
        .BranchTarget(BranchTarget),
        .Instr(Instr),
        .InstrValid(InstrValid),
        .PC(PC),
        .PCPlus8(PCPlus8),
        .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic drive(input bit r, input bit rdy, input logic [31:0] rd,
                         input bit st, input bit ps, input logic [31:0] bt);
        reset        = r;
        imem_ready   = rdy;
        imem_rdata   = rd;
        stall        = st;
        PCSrc        = ps;
        BranchTarget = bt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_pc    = RPC;
            m_instr = 32'h0;
            m_have  = 0;
            m_dead  = 0;
        end else if (m_dead) begin
        end else if (!m_have) begin
            if (imem_ready) begin
                m_instr = imem_rdata;
                m_have  = 1;
            end
        end else if (!stall) begin
            if (!PCSrc) begin
                m_pc   = m_pc + 32'd4;
                m_have = 0;
            end else if (BranchTarget % 4 == 0) begin
                m_pc   = BranchTarget;
                m_have = 0;
            end else begin
                m_dead = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        drive(1, 1, 32'h1234_5678, 0, 0, 0);
        tick();
        drive(1, 1, 32'h1234_5678, 0, 0, 0);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req got=%b exp=0", imem_req);
        end
        checks++;
        if (PC !== RPC || Instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs pc=%h instr=%h exp=%h/0", PC, Instr, RPC);
        end
        checks++;
        if (fault !== 1'b0 || InstrValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags fault=%b valid=%b exp=0/0", fault, InstrValid);
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RPC) begin
            errors++;
            $display("FAIL first_req req=%b addr=%h exp=1/%h", imem_req, imem_addr, RPC);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 32'hA000_0000 + i, 0, 0, 0);
            checks++;
            if (InstrValid !== 1'(i % 2)) begin
                errors++;
                $display("FAIL seq_valid i=%0d got=%b exp=%b", i, InstrValid, 1'(i % 2));
            end
            if (i % 2 == 0) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (i / 2))) begin
                    errors++;
                    $display("FAIL seq_addr i=%0d req=%b addr=%h exp=1/%h",
                             i, imem_req, imem_addr, 32'(4 * (i / 2)));
                end
            end else begin
                checks++;
                if (Instr !== 32'hA000_0000 + i - 1) begin
                    errors++;
                    $display("FAIL seq_instr i=%0d got=%h exp=%h", i, Instr,
                             32'hA000_0000 + i - 1);
                end
            end
            if (i < 2) begin
                checks++;
                if (PCPlus8 !== 32'h8) begin
                    errors++;
                    $display("FAIL seq_pc8 got=%h exp=8", PCPlus8);
                end
            end
            tick();
        end
    endtask

    task automatic test_wait();
        do_reset();
        drive(0, 1, 32'h0, 0, 0, 0);
        tick();
        drive(0, 0, 32'h0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 32'hFFFF_FFFF, 0, 0, 0);
            checks++;
            if (imem_addr !== 32'h4 || imem_req !== 1'b1 || InstrValid !== 1'b0) begin
                errors++;
                $display("FAIL wait_addr i=%0d addr=%h req=%b valid=%b exp=4/1/0",
                         i, imem_addr, imem_req, InstrValid);
            end
            tick();
        end
        drive(0, 1, 32'hE3A0_1005, 0, 0, 0);
        tick();
        drive(0, 0, 32'h0, 1, 0, 0);
        checks++;
        if (Instr !== 32'hE3A0_1005 || InstrValid !== 1'b1) begin
            errors++;
            $display("FAIL wait_capture instr=%h valid=%b exp=e3a01005/1", Instr, InstrValid);
        end
    endtask

    task automatic test_stall();
        drive(0, 0, 32'h0, 0, 0, 0);
        tick();
        drive(0, 1, 32'h0000_0011, 0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 32'h5555_5555, 1, 1, 32'h100);
            checks++;
            if (Instr !== 32'h11 || PC !== 32'h8 || InstrValid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold i=%0d instr=%h pc=%h valid=%b exp=11/8/1",
                         i, Instr, PC, InstrValid);
            end
            tick();
        end
        drive(0, 0, 32'h0, 0, 0, 32'h100);
        tick();
        drive(0, 0, 32'h0, 0, 0, 0);
        checks++;
        if (imem_addr !== 32'hC || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL stall_next addr=%h req=%b exp=c/1", imem_addr, imem_req);
        end
    endtask

    task automatic test_redirect();
        drive(0, 1, 32'h0, 0, 0, 0);
        tick();
        drive(0, 0, 32'h0, 0, 1, 32'h40);
        tick();
        drive(0, 0, 32'h0, 0, 0, 0);
        checks++;
        if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL redirect addr=%h req=%b exp=40/1", imem_addr, imem_req);
        end
        drive(0, 1, 32'h0, 0, 0, 0);
        tick();
        drive(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC);
        tick();
        drive(0, 1, 32'h0, 0, 0, 0);
        tick();
        drive(0, 0, 32'h0, 0, 0, 0);
        tick();
        drive(0, 0, 32'h0, 0, 0, 0);
        checks++;
        if (imem_addr !== 32'h0 || PCPlus8 !== 32'h8) begin
            errors++;
            $display("FAIL wrap addr=%h pc8=%h exp=0/8", imem_addr, PCPlus8);
        end
    endtask

    task automatic test_fault();
        do_reset();
        drive(0, 1, 32'hCAFE_0001, 0, 0, 0);
        tick();
        drive(0, 0, 32'h0, 0, 1, 32'h42);
        tick();
        for (int i = 0; i < 12; i++) begin
            drive(0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 32'h80);
            checks++;
            if (fault !== 1'b1 || imem_req !== 1'b0 || InstrValid !== 1'b0 ||
                PC !== 32'h0 || Instr !== 32'hCAFE_0001) begin
                errors++;
                $display("FAIL fault_lock i=%0d f=%b req=%b v=%b pc=%h ins=%h exp=1/0/0/0/cafe0001",
                         i, fault, imem_req, InstrValid, PC, Instr);
            end
            tick();
        end
        drive(1, 1, 32'h0, 0, 0, 0);
        tick();
        drive(0, 0, 32'h0, 0, 0, 0);
        checks++;
        if (fault !== 1'b0 || imem_addr !== RPC || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL fault_clear f=%b addr=%h req=%b exp=0/%h/1",
                     fault, imem_addr, imem_req, RPC);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(0, 1, 32'h0, 0, 0, 0);
        tick();
        drive(0, 0, 32'h0, 0, 1, 32'h20);
        tick();
        drive(1, 1, 32'hDEAD_BEEF, 0, 0, 0);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL mid_req got=%b exp=0", imem_req);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 32'h0, 0, 0, 0);
            checks++;
            if (Instr !== 32'h0 || PC !== RPC || InstrValid !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset i=%0d instr=%h pc=%h valid=%b exp=0/%h/0",
                         i, Instr, PC, InstrValid, RPC);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [130:0] got;
        logic [130:0] exp;
        logic [31:0]  bt;
        bit           r;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            bt = $urandom;
            if ($urandom_range(0, 7) != 0)
                bt[1:0] = 2'b00;
            drive(r, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0), bt);
            got = {imem_req, imem_addr, Instr, InstrValid, PC, fault};
            exp = {!r && !m_dead && !m_have, m_pc, m_instr, m_have && !m_dead,
                   m_pc, m_dead};
            checks++;
            if (got !== exp || PCPlus8 !== m_pc + 32'd8) begin
                errors++;
                $display("FAIL random i=%0d got=%h exp=%h pc8=%h", i, got, exp, PCPlus8);
            end
            tick();
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        test_reset();
        test_sequential();
        test_wait();
        test_stall();
        test_redirect();
        test_fault();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
